diag_cmd_streamer: RTL and testbench

Command-stream source for the diagnostics chain. It holds a writable table of 19-bit I2C command words in block RAM and, on a start pulse, streams them in address order over a valid/ready handshake into the command interpreter that drives the I2C reader. It stops at an end-marker word or at the last table entry. A two-entry output buffer sustains one word per clock despite the synchronous RAM read latency.

---
 rtl/diag_cmd_streamer_if.sv | 19 +
 rtl/diag_cmd_streamer.sv | 139 +++++++++++++
 tb/tb_diag_cmd_streamer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/diag_cmd_streamer_if.sv
// Command word stream between the table streamer and the interpreter.
// The streamer drives data/valid; the interpreter drives ready.
interface diag_cmd_streamer_if;
    logic [18:0] raw_data_o19b;
    logic        valid_o;
    logic        ready_i;

    modport master (
        output raw_data_o19b,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  raw_data_o19b,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/diag_cmd_streamer.sv
// Streams a writable table of 19-bit I2C command words in address order,
// stopping at an end-marker word or the last entry.
module diag_cmd_streamer #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [18:0] END_MARK = 19'h7FFFF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [18:0]         wr_data_i19b,
    diag_cmd_streamer_if.master cmd,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W:0]     count_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [18:0]       mem [DEPTH];
    logic [18:0]       ram_q;
    logic [18:0]       head;
    logic [18:0]       tail;
    logic [1:0]        occ;
    logic [1:0]        level;
    logic              rd_vld;
    logic              rd_last;
    logic              last_iss;
    logic [ADDR_W-1:0] rd_addr;
    logic              hs;
    logic              is_end;
    logic              push;
    logic              issue;
    logic              wr_ok;

    assign cmd.valid_o       = (occ != 2'd0);
    assign cmd.raw_data_o19b = head;

    assign hs     = cmd.valid_o & cmd.ready_i;
    assign is_end = rd_vld && (ram_q == END_MARK);
    assign push   = rd_vld && !is_end;
    // Occupancy after this edge plus the read now in flight must stay <= 2.
    assign level  = occ + {1'b0, rd_vld} - {1'b0, hs};
    assign issue  = (state == FETCH) && !last_iss && !is_end
                    && (level < 2'd2);
    assign wr_ok  = wr_en_i && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr_i] <= wr_data_i19b;
        if (issue)
            ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            occ      <= 2'd0;
            head     <= '0;
            tail     <= '0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            last_iss <= 1'b0;
            rd_addr  <= '0;
            count_o  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            busy_o <= (state == FETCH) || (state == DRAIN);
            done_o <= 1'b0;
            rd_vld <= issue;

            if (issue) begin
                rd_last  <= &rd_addr;
                last_iss <= &rd_addr;
                rd_addr  <= rd_addr + 1'b1;
            end

            if (hs)
                count_o <= count_o + 1'b1;

            unique case ({push, hs})
                2'b10: begin
                    if (occ == 2'd0)
                        head <= ram_q;
                    else
                        tail <= ram_q;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= ram_q;
                    end else begin
                        head <= tail;
                        tail <= ram_q;
                    end
                end
                default: ;
            endcase

            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= FETCH;
                        rd_addr  <= '0;
                        last_iss <= 1'b0;
                        count_o  <= '0;
                        occ      <= 2'd0;
                    end
                end
                FETCH: begin
                    if (is_end || (rd_vld && rd_last))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (occ == 2'd0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diag_cmd_streamer.sv
// Scoreboard bench for diag_cmd_streamer on a 4-entry table.
// Expected words are queued at stimulus time and popped on each handshake.
module tb_diag_cmd_streamer;

    localparam int          DEPTH = 4;
    localparam int          AW    = 2;
    localparam logic [18:0] EM    = 19'h7FFFF;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [18:0]   wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    diag_cmd_streamer_if bus ();

    diag_cmd_streamer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .END_MARK (EM)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i19b (wr_data),
        .cmd          (bus),
        .busy_o       (busy),
        .done_o       (done),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [18:0] exp_q[$];
    int          done_cnt = 0;
    bit          seen_valid = 1'b0;
    bit          prev_stall = 1'b0;
    logic [18:0] prev_data = '0;
    int          rdy_mode = 0;
    int          rdy_k = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, other: never ready
    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: bus.ready_i = 1'b1;
                1: begin
                    bus.ready_i = (rdy_k % 4 == 0) || (rdy_k % 4 == 3);
                    rdy_k++;
                end
                default: bus.ready_i = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (done)
                done_cnt++;
            if (bus.valid_o)
                seen_valid = 1'b1;
            if (prev_stall && bus.valid_o)
                check("stable", bus.raw_data_o19b, prev_data);
            if (bus.valid_o && bus.ready_i) begin
                check("no_end_mark", bus.raw_data_o19b == EM, 0);
                if (exp_q.size() == 0)
                    check("extra_word", 1, 0);
                else
                    check("data", bus.raw_data_o19b, exp_q.pop_front());
            end
            prev_stall = bus.valid_o && !bus.ready_i;
            prev_data  = bus.raw_data_o19b;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wr(input int a, input logic [18:0] d);
        @(posedge clk);
        #2;
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        @(posedge clk);
        #2;
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [18:0] w0, input logic [18:0] w1,
                        input logic [18:0] w2, input logic [18:0] w3);
        wr(0, w0);
        wr(1, w1);
        wr(2, w2);
        wr(3, w3);
    endtask

    task automatic expect3(input logic [18:0] a, input logic [18:0] b,
                           input logic [18:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cnt);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_count"}, count, exp_cnt);
        check({tag, "_busy_in_done"}, busy, 1);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        check({tag, "_one_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        rstn    = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.valid_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_data", bus.raw_data_o19b, 0);
        @(posedge clk);
        #2 rstn = 1'b1;

        // basic stream with ready held high
        load(19'h1, 19'h2, 19'h3, EM);
        expect3(19'h1, 19'h2, 19'h3);
        pulse_start;
        @(negedge clk);
        check("t1_busy_c0", busy, 0);
        @(negedge clk);
        check("t1_busy_c1", busy, 1);
        check("t1_valid_c1", bus.valid_o, 0);
        @(negedge clk);
        check("t1_valid_c2", bus.valid_o, 1);
        check("t1_first", bus.raw_data_o19b, 19'h1);
        @(negedge clk);
        check("t1_valid_c3", bus.valid_o, 1);
        @(negedge clk);
        check("t1_valid_c4", bus.valid_o, 1);
        wait_done("t1", 3);

        // back-pressure pattern
        rdy_k    = 0;
        rdy_mode = 1;
        expect3(19'h1, 19'h2, 19'h3);
        pulse_start;
        wait_done("t2", 3);
        rdy_mode = 0;

        // empty stream
        wr(0, EM);
        seen_valid = 1'b0;
        pulse_start;
        wait_done("t3", 0);
        check("t3_no_valid", seen_valid, 0);

        // full table, no marker
        load(19'h10, 19'h11, 19'h12, 19'h13);
        expect3(19'h10, 19'h11, 19'h12);
        exp_q.push_back(19'h13);
        pulse_start;
        wait_done("t4", 4);

        // reset while the second word is waiting
        load(19'h1, 19'h2, 19'h3, EM);
        expect3(19'h1, 19'h2, 19'h3);
        pulse_start;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.valid_o && bus.raw_data_o19b == 19'h1) && n < 50);
        check("t5_first_seen", n < 50, 1);
        rdy_mode = 2;
        @(negedge clk);
        check("t5_second_valid", bus.valid_o, 1);
        check("t5_second_head", bus.raw_data_o19b, 19'h2);
        d0   = done_cnt;
        rstn = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", bus.valid_o, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_count", count, 0);
        check("t5_rst_data", bus.raw_data_o19b, 0);
        rstn = 1'b1;
        exp_q.delete();
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        expect3(19'h1, 19'h2, 19'h3);
        pulse_start;
        wait_done("t5b", 3);

        // write and start while busy are ignored
        rdy_mode = 2;
        expect3(19'h1, 19'h2, 19'h3);
        pulse_start;
        repeat (3) @(negedge clk);
        check("t6_busy", busy, 1);
        wr(1, 19'h55);
        pulse_start;
        @(negedge clk);
        check("t6_busy_still", busy, 1);
        check("t6_count_held", count, 0);
        rdy_mode = 0;
        wait_done("t6", 3);
        expect3(19'h1, 19'h2, 19'h3);
        pulse_start;
        wait_done("t6b", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
